uart_echo_buffered: RTL and testbench

//  Parametrised UART loopback: receives bytes on rx and re-transmits them on tx.
//  A FIFO decouples the receiver from the transmitter, so back-to-back bytes are
//  not lost while tx is busy. An optional character filter runs on the tx path:

---
 rtl/uart_echo_buffered.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_uart_echo_buffered.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_echo_buffered.sv
// UART loopback with a byte FIFO between receiver and transmitter.
// Optional tx-path filters: lower-to-upper case mapping and CR -> CR LF expansion.
// Contains uart_rx, uart_tx and the top-level uart_echo_buffered.

// 8N1 receiver: two-flop synchroniser, mid-bit sampling, one-cycle valid pulse per good frame.
module uart_rx #(
    parameter int SYSTEM_CLOCK = 32000000,
    parameter int BAUD_RATE    = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data_rx,
    output logic       valid
);
    localparam int CPB = SYSTEM_CLOCK / BAUD_RATE;
    localparam int CW  = $clog2(CPB);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t      state;
    logic [1:0]     sync;
    logic [CW-1:0]  cnt;
    logic [2:0]     bit_idx;
    logic [7:0]     sh;

    // Frame decoder: hunt for start edge, confirm at mid-start, sample each bit at its centre.
    // NOTE: sequential state uses <= so every flop samples values from before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync    <= 2'b11;
            state   <= RX_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            sh      <= '0;
            data_rx <= '0;
            valid   <= 1'b0;
        end else begin
            sync  <= {sync[0], rx};
            valid <= 1'b0;
            case (state)
                RX_IDLE: begin
                    cnt <= '0;
                    if (!sync[1]) state <= RX_START;
                end
                RX_START: begin
                    if (cnt == CW'(CPB / 2 - 1)) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= sync[1] ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt == CW'(CPB - 1)) begin
                        cnt     <= '0;
                        sh      <= {sync[1], sh[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) state <= RX_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt == CW'(CPB - 1)) begin
                        cnt   <= '0;
                        state <= RX_IDLE;
                        if (sync[1]) begin
                            valid   <= 1'b1;
                            data_rx <= sh;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// 8N1 transmitter: accepts a byte on en while rdy, drives start, 8 data bits LSB first, stop.
module uart_tx #(
    parameter int SYSTEM_CLOCK = 32000000,
    parameter int BAUD_RATE    = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] data_in,
    output logic       rdy,
    output logic       tx
);
    localparam int CPB = SYSTEM_CLOCK / BAUD_RATE;
    localparam int CW  = $clog2(CPB);

    logic          busy;
    logic [8:0]    sh;
    logic [3:0]    bit_idx;
    logic [CW-1:0] cnt;

    assign rdy = !busy;

    // Bit sequencer: start bit is driven on acceptance, then one shift per bit period.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy    <= 1'b0;
            tx      <= 1'b1;
            sh      <= '1;
            bit_idx <= '0;
            cnt     <= '0;
        end else if (!busy) begin
            cnt     <= '0;
            bit_idx <= '0;
            if (en) begin
                busy <= 1'b1;
                tx   <= 1'b0;
                sh   <= {1'b1, data_in};
            end
        end else if (cnt == CW'(CPB - 1)) begin
            cnt <= '0;
            if (bit_idx == 4'd9) begin
                busy <= 1'b0;
            end else begin
                tx      <= sh[0];
                sh      <= {1'b1, sh[8:1]};
                bit_idx <= bit_idx + 1'b1;
            end
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// Top level: rx -> edge capture -> FIFO -> filter FSM -> tx.
module uart_echo_buffered #(
    parameter int SYSTEM_CLOCK = 32000000,
    parameter int BAUD_RATE    = 9600,
    parameter int FIFO_DEPTH   = 16,
    parameter int UPCASE       = 0,
    parameter int CRLF         = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx,
    output logic                          tx,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {IDLE, LOAD, BUSY, DONE} state_t;

    logic          valid;
    logic [7:0]    data_rx;
    logic          en;
    logic          rdy;
    logic [7:0]    cur;
    logic [7:0]    cur_nx;
    logic          crlf_pend;
    logic          crlf_nx;
    state_t        state;
    state_t        state_nx;

    logic          valid_q;
    logic          push;
    logic [7:0]    push_data;
    logic          pop;
    logic          full;
    logic          empty;
    logic          wr_ok;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [7:0]    mem [FIFO_DEPTH];

    uart_rx #(.SYSTEM_CLOCK(SYSTEM_CLOCK), .BAUD_RATE(BAUD_RATE)) u_rx (
        .clk     (clk),
        .rst     (rst),
        .rx      (rx),
        .data_rx (data_rx),
        .valid   (valid)
    );

    uart_tx #(.SYSTEM_CLOCK(SYSTEM_CLOCK), .BAUD_RATE(BAUD_RATE)) u_tx (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .data_in (cur),
        .rdy     (rdy),
        .tx      (tx)
    );

    function automatic logic [7:0] map_byte(input logic [7:0] b);
        if (UPCASE != 0 && b >= 8'h61 && b <= 8'h7A) map_byte = b - 8'h20;
        else                                          map_byte = b;
    endfunction

    assign full  = (fifo_level == LW'(FIFO_DEPTH));
    assign empty = (fifo_level == '0);
    assign wr_ok = push && (!full || pop);

    // Capture: one push per rising edge of valid, byte sampled alongside the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            push      <= 1'b0;
            push_data <= '0;
        end else begin
            valid_q <= valid;
            push    <= valid && !valid_q;
            if (valid && !valid_q) push_data <= data_rx;
        end
    end

    // FIFO storage write.
    // NOTE: the byte array has no reset; pointers and level alone define which entries are live.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= push_data;
    end

    // FIFO bookkeeping: pointers wrap naturally, level tracks push/pop, overflow is sticky.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            if (push && !wr_ok) overflow <= 1'b1;
            case ({wr_ok, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // TX FSM state register with the current byte and pending-LF flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cur       <= '0;
            crlf_pend <= 1'b0;
        end else begin
            state     <= state_nx;
            cur       <= cur_nx;
            crlf_pend <= crlf_nx;
        end
    end

    // TX FSM next state: pop and map in IDLE, one-cycle en in LOAD, LF insertion in DONE.
    // NOTE: every output gets a default first so no path leaves a latch behind.
    always_comb begin
        state_nx = state;
        cur_nx   = cur;
        crlf_nx  = crlf_pend;
        en       = 1'b0;
        pop      = 1'b0;
        case (state)
            IDLE: begin
                if (!empty && rdy) begin
                    pop      = 1'b1;
                    cur_nx   = map_byte(mem[rd_ptr]);
                    state_nx = LOAD;
                end
            end
            LOAD: begin
                en       = 1'b1;
                state_nx = BUSY;
            end
            BUSY: begin
                if (!rdy) state_nx = DONE;
            end
            DONE: begin
                if (rdy) begin
                    if (CRLF != 0 && cur == 8'h0D && !crlf_pend) begin
                        crlf_nx  = 1'b1;
                        cur_nx   = 8'h0A;
                        state_nx = LOAD;
                    end else begin
                        crlf_nx  = 1'b0;
                        state_nx = IDLE;
                    end
                end
            end
        endcase
    end
endmodule

// File: tb/tb_uart_echo_buffered.sv
// Bench for uart_echo_buffered: two instances share rx and rst.
// dut0: plain echo. dut1: UPCASE and CRLF enabled. Both tx lines are decoded into byte queues.
module tb_uart_echo_buffered;
    localparam int SC = 1000000;
    localparam int BR = 100000;
    localparam int FD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic       tx0, tx1;
    logic [2:0] lvl0, lvl1;
    logic       ov0, ov1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_echo_buffered #(.SYSTEM_CLOCK(SC), .BAUD_RATE(BR), .FIFO_DEPTH(FD), .UPCASE(0), .CRLF(0)) dut0 (
        .clk(clk), .rst(rst), .rx(rx), .tx(tx0), .fifo_level(lvl0), .overflow(ov0));
    uart_echo_buffered #(.SYSTEM_CLOCK(SC), .BAUD_RATE(BR), .FIFO_DEPTH(FD), .UPCASE(1), .CRLF(1)) dut1 (
        .clk(clk), .rst(rst), .rx(rx), .tx(tx1), .fifo_level(lvl1), .overflow(ov1));

    // Frame decoders on both tx lines, sampled on the falling clock edge.
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int         m_cnt [2];
    logic       m_busy[2];
    logic [7:0] m_sh  [2];
    logic       m_line;
    int         frame_err = 0;

    initial begin
        m_busy[0] = 1'b0;
        m_busy[1] = 1'b0;
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            m_line = (i == 0) ? tx0 : tx1;
            if (rst) begin
                m_busy[i] = 1'b0;
            end else if (!m_busy[i]) begin
                if (m_line === 1'b0) begin
                    m_busy[i] = 1'b1;
                    m_cnt[i]  = 0;
                end
            end else begin
                m_cnt[i]++;
                if (m_cnt[i] >= 15 && m_cnt[i] <= 85 && (m_cnt[i] % 10) == 5)
                    m_sh[i] = {m_line, m_sh[i][7:1]};
                if (m_cnt[i] == 95) begin
                    if (m_line === 1'b1) begin
                        if (i == 0) q0.push_back(m_sh[i]);
                        else        q1.push_back(m_sh[i]);
                    end else begin
                        frame_err++;
                    end
                    m_busy[i] = 1'b0;
                end
            end
        end
    end

    // en bookkeeping: pulse counts, protocol violations, valid-to-en latency on dut0.
    int   cyc = 0;
    int   en_cnt0 = 0, en_cnt1 = 0;
    int   viol = 0;
    logic en_prev0 = 1'b0, en_prev1 = 1'b0, v_prev = 1'b0;
    int   t_valid = 0, t_en = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (dut0.en === 1'b1) begin
            en_cnt0++;
            t_en = cyc;
            if (dut0.rdy !== 1'b1 || en_prev0) viol++;
        end
        if (dut1.en === 1'b1) begin
            en_cnt1++;
            if (dut1.rdy !== 1'b1 || en_prev1) viol++;
        end
        if (dut0.valid === 1'b1 && !v_prev) t_valid = cyc;
        en_prev0 = (dut0.en === 1'b1);
        en_prev1 = (dut1.en === 1'b1);
        v_prev   = (dut0.valid === 1'b1);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [7:0] inj_data = 8'h00;

    task tick;
        @(posedge clk);
        #1;
    endtask

    task do_reset;
        rst = 1'b1;
        repeat (3) tick;
        rst = 1'b0;
        tick;
    endtask

    task send_byte(input logic [7:0] b);
        rx = 1'b0;
        repeat (10) tick;
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (10) tick;
        end
        rx = 1'b1;
        repeat (10) tick;
    endtask

    // Drive the capture path directly with one valid edge every two cycles (no serial latency).
    task inject(input logic [7:0] b);
        inj_data = b;
        force dut0.data_rx = inj_data;
        force dut1.data_rx = inj_data;
        force dut0.valid = 1'b1;
        force dut1.valid = 1'b1;
        tick;
        force dut0.valid = 1'b0;
        force dut1.valid = 1'b0;
        tick;
    endtask

    task inject_done;
        release dut0.valid;
        release dut1.valid;
        release dut0.data_rx;
        release dut1.data_rx;
    endtask

    task wait_frames(input int n0, input int n1, input int budget, input string name);
        int k;
        k = 0;
        while ((q0.size() < n0 || q1.size() < n1) && k < budget) begin
            tick;
            k++;
        end
        total++;
        if (q0.size() < n0 || q1.size() < n1) begin
            bad++;
            $display("FAIL %s frames: got %0d/%0d want %0d/%0d", name, q0.size(), q1.size(), n0, n1);
        end
    endtask

    task wait_idle(input int budget, input string name);
        int k;
        k = 0;
        while (!(dut0.state == 2'd0 && dut1.state == 2'd0 && lvl0 == 3'd0 && lvl1 == 3'd0
                 && dut0.rdy === 1'b1 && dut1.rdy === 1'b1) && k < budget) begin
            tick;
            k++;
        end
        total++;
        if (k >= budget) begin
            bad++;
            $display("FAIL %s drain: lvl0=%0d lvl1=%0d not idle after %0d cycles", name, lvl0, lvl1, budget);
        end
    endtask

    task test_reset;
        do_reset;
        @(negedge clk);
        total += 5;
        if (lvl0 !== 3'd0)      begin bad++; $display("FAIL reset_level: got %0d want 0", lvl0); end
        if (ov0 !== 1'b0)       begin bad++; $display("FAIL reset_overflow: got %b want 0", ov0); end
        if (tx0 !== 1'b1)       begin bad++; $display("FAIL reset_tx: got %b want 1", tx0); end
        if (dut0.state != 2'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", dut0.state); end
        if (dut0.en !== 1'b0)   begin bad++; $display("FAIL reset_en: got %b want 0", dut0.en); end
    endtask

    task test_basic;
        int e0, e1;
        q0.delete(); q1.delete();
        e0 = en_cnt0; e1 = en_cnt1;
        send_byte(8'h61);
        wait_frames(1, 1, 400, "basic");
        wait_idle(200, "basic");
        @(negedge clk);
        total += 6;
        if (q0[0] !== 8'h61)     begin bad++; $display("FAIL basic_echo: got %h want 61", q0[0]); end
        if (q1[0] !== 8'h41)     begin bad++; $display("FAIL basic_upcase: got %h want 41", q1[0]); end
        if (en_cnt0 - e0 != 1)   begin bad++; $display("FAIL basic_en0: got %0d pulses want 1", en_cnt0 - e0); end
        if (en_cnt1 - e1 != 1)   begin bad++; $display("FAIL basic_en1: got %0d pulses want 1", en_cnt1 - e1); end
        if (lvl0 !== 3'd0)       begin bad++; $display("FAIL basic_level: got %0d want 0", lvl0); end
        if (t_en - t_valid != 3) begin bad++; $display("FAIL basic_latency: got %0d cycles want 3", t_en - t_valid); end
    endtask

    task test_upcase;
        logic [7:0] in_b  [3];
        logic [7:0] exp_1 [3];
        in_b  = '{8'h61, 8'h5A, 8'h7B};
        exp_1 = '{8'h41, 8'h5A, 8'h7B};
        q0.delete(); q1.delete();
        for (int i = 0; i < 3; i++) send_byte(in_b[i]);
        wait_frames(3, 3, 600, "upcase");
        wait_idle(200, "upcase");
        for (int i = 0; i < 3; i++) begin
            total += 2;
            if (q0[i] !== in_b[i])  begin bad++; $display("FAIL upcase_plain[%0d]: got %h want %h", i, q0[i], in_b[i]); end
            if (q1[i] !== exp_1[i]) begin bad++; $display("FAIL upcase_map[%0d]: got %h want %h", i, q1[i], exp_1[i]); end
        end
    endtask

    task test_crlf;
        int e0, e1;
        logic [7:0] exp_1 [3];
        exp_1 = '{8'h0D, 8'h0A, 8'h31};
        q0.delete(); q1.delete();
        e0 = en_cnt0; e1 = en_cnt1;
        send_byte(8'h0D);
        send_byte(8'h31);
        wait_frames(2, 3, 800, "crlf");
        wait_idle(300, "crlf");
        repeat (50) tick;
        total += 6;
        if (q0.size() != 2)          begin bad++; $display("FAIL crlf_plain_count: got %0d want 2", q0.size()); end
        if (q0[0] !== 8'h0D || q0[1] !== 8'h31)
                                     begin bad++; $display("FAIL crlf_plain: got %h %h want 0d 31", q0[0], q0[1]); end
        if (q1.size() != 3)          begin bad++; $display("FAIL crlf_count: got %0d want 3", q1.size()); end
        if (en_cnt0 - e0 != 2)       begin bad++; $display("FAIL crlf_en0: got %0d pulses want 2", en_cnt0 - e0); end
        if (en_cnt1 - e1 != 3)       begin bad++; $display("FAIL crlf_en1: got %0d pulses want 3", en_cnt1 - e1); end
        if (dut1.crlf_pend !== 1'b0) begin bad++; $display("FAIL crlf_pend: got %b want 0", dut1.crlf_pend); end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (q1[i] !== exp_1[i]) begin bad++; $display("FAIL crlf_seq[%0d]: got %h want %h", i, q1[i], exp_1[i]); end
        end
    endtask

    task test_overflow;
        q0.delete(); q1.delete();
        for (int b = 1; b <= 6; b++) inject(8'(b));
        inject_done;
        @(negedge clk);
        total += 2;
        if (lvl0 !== 3'd4) begin bad++; $display("FAIL ovf_full: got level %0d want 4", lvl0); end
        if (ov0 !== 1'b1)  begin bad++; $display("FAIL ovf_set: got %b want 1", ov0); end
        wait_frames(5, 5, 900, "overflow");
        wait_idle(300, "overflow");
        repeat (200) tick;
        total += 3;
        if (q0.size() != 5 || q1.size() != 5)
            begin bad++; $display("FAIL ovf_count: got %0d/%0d want 5/5", q0.size(), q1.size()); end
        if (ov0 !== 1'b1 || ov1 !== 1'b1)
            begin bad++; $display("FAIL ovf_sticky: got %b/%b want 1/1", ov0, ov1); end
        if (lvl0 !== 3'd0) begin bad++; $display("FAIL ovf_drain: got level %0d want 0", lvl0); end
        for (int i = 0; i < 5; i++) begin
            total += 2;
            if (q0[i] !== 8'(i + 1)) begin bad++; $display("FAIL ovf_seq0[%0d]: got %h want %h", i, q0[i], 8'(i + 1)); end
            if (q1[i] !== 8'(i + 1)) begin bad++; $display("FAIL ovf_seq1[%0d]: got %h want %h", i, q1[i], 8'(i + 1)); end
        end
    endtask

    task test_reset_mid;
        int k, e0, e1;
        q0.delete(); q1.delete();
        inject(8'hA1);
        inject(8'hA2);
        inject(8'hA3);
        inject_done;
        k = 0;
        while (tx0 !== 1'b0 && k < 50) begin tick; k++; end
        total++;
        if (tx0 !== 1'b0) begin bad++; $display("FAIL rstmid_start: tx0 got %b want 0", tx0); end
        repeat (25) tick;
        @(negedge clk);
        total += 2;
        if (lvl0 !== 3'd2 || lvl1 !== 3'd2)
            begin bad++; $display("FAIL rstmid_queued: got %0d/%0d want 2/2", lvl0, lvl1); end
        if (ov0 !== 1'b1) begin bad++; $display("FAIL rstmid_ovf_before: got %b want 1", ov0); end
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        @(negedge clk);
        total += 5;
        if (lvl0 !== 3'd0 || lvl1 !== 3'd0)
            begin bad++; $display("FAIL rstmid_level: got %0d/%0d want 0/0", lvl0, lvl1); end
        if (ov0 !== 1'b0 || ov1 !== 1'b0)
            begin bad++; $display("FAIL rstmid_overflow: got %b/%b want 0/0", ov0, ov1); end
        if (dut0.state != 2'd0 || dut1.state != 2'd0)
            begin bad++; $display("FAIL rstmid_state: got %0d/%0d want 0/0", dut0.state, dut1.state); end
        if (tx0 !== 1'b1 || tx1 !== 1'b1)
            begin bad++; $display("FAIL rstmid_tx: got %b/%b want 1/1", tx0, tx1); end
        if (dut1.crlf_pend !== 1'b0)
            begin bad++; $display("FAIL rstmid_crlf: got %b want 0", dut1.crlf_pend); end
        e0 = en_cnt0; e1 = en_cnt1;
        repeat (300) tick;
        total += 2;
        if (en_cnt0 != e0 || en_cnt1 != e1)
            begin bad++; $display("FAIL rstmid_en: got %0d/%0d extra pulses want 0", en_cnt0 - e0, en_cnt1 - e1); end
        if (q0.size() != 0 || q1.size() != 0)
            begin bad++; $display("FAIL rstmid_frames: got %0d/%0d want 0/0", q0.size(), q1.size()); end
    endtask

    task test_wrap;
        logic [7:0] exp_b [9];
        exp_b = '{8'h11, 8'h12, 8'h13, 8'h21, 8'h22, 8'h23, 8'h31, 8'h32, 8'h33};
        q0.delete(); q1.delete();
        for (int b = 0; b < 3; b++) begin
            for (int j = 0; j < 3; j++) send_byte(exp_b[b * 3 + j]);
            wait_frames(b * 3 + 3, b * 3 + 3, 600, "wrap");
            wait_idle(300, "wrap");
        end
        @(negedge clk);
        total += 3;
        if (ov0 !== 1'b0 || ov1 !== 1'b0)
            begin bad++; $display("FAIL wrap_overflow: got %b/%b want 0/0", ov0, ov1); end
        if (dut0.wr_ptr !== 2'd1 || dut0.rd_ptr !== 2'd1)
            begin bad++; $display("FAIL wrap_ptr: got wr=%0d rd=%0d want 1/1", dut0.wr_ptr, dut0.rd_ptr); end
        if (q0.size() != 9) begin bad++; $display("FAIL wrap_count: got %0d want 9", q0.size()); end
        for (int i = 0; i < 9; i++) begin
            total += 2;
            if (q0[i] !== exp_b[i]) begin bad++; $display("FAIL wrap_seq0[%0d]: got %h want %h", i, q0[i], exp_b[i]); end
            if (q1[i] !== exp_b[i]) begin bad++; $display("FAIL wrap_seq1[%0d]: got %h want %h", i, q1[i], exp_b[i]); end
        end
    endtask

    task test_protocol;
        total += 2;
        if (viol != 0)      begin bad++; $display("FAIL en_protocol: got %0d violations want 0", viol); end
        if (frame_err != 0) begin bad++; $display("FAIL tx_framing: got %0d bad stop bits want 0", frame_err); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_upcase;
        test_crlf;
        do_reset;
        test_overflow;
        test_reset_mid;
        test_wrap;
        test_protocol;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
